serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor computing a - b (- bin), LSB first.

---
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor (a - b [- bin]), LSB first,
//               one full-subtractor cell and a registered borrow.
//               Optional initial-borrow port enabled by SERIAL_SUB_BIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
   input  logic             bin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_diff;
   logic             r_br;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;

   logic             w_x;
   logic             w_y;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_last;
   logic             w_bin_init;

`ifdef SERIAL_SUB_BIN_EN
   assign w_bin_init = bin;
`else
   assign w_bin_init = 1'b0;
`endif

   // Full-subtractor cell
   assign w_x      = r_sa[0];
   assign w_y      = r_sb[0];
   assign w_d      = w_x ^ w_y ^ r_br;
   assign w_br_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // The minuend register doubles as the result register: each vacated MSB
   // receives the next difference bit, so after WIDTH shifts it holds the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa     <= '0;
         r_sb     <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sa  <= a;
                  r_sb  <= b;
                  r_br  <= w_bin_init;
                  r_cnt <= '0;
               end
            end
            S_SHIFT: begin
               r_sa  <= {w_d, r_sa[WIDTH-1:1]};
               r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
               r_br  <= w_br_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_diff   <= {w_d, r_sa[WIDTH-1:1]};
                  r_borrow <= w_br_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign diff   = r_diff;
   assign borrow = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8): vector
//               table, random operands against an arithmetic model, corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
`ifdef SERIAL_SUB_BIN_EN
      .bin    (bin),
`endif
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vbin;
      logic [W-1:0] ed;
      logic         eb;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                        output logic [W-1:0] md, output logic mbw);
      int ia, isub;
      ia   = int'(ma);
      isub = int'(mb) + int'(mbin);
      md   = W'((ia - isub) & ((1 << W) - 1));
      mbw  = (ia < isub);
   endtask

   // Caller is at a negedge in IDLE. start is asserted immediately. inj > 0
   // re-pulses start with other operands in SHIFT cycle inj; p_done pulses
   // start during the DONE cycle. Returns at a negedge in IDLE.
   task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vbin, input int inj, input bit p_done);
      logic [W-1:0] ed;
      logic         eb;
      int           lat, nbusy;
      model(va, vb, vbin, ed, eb);
      a = va; b = vb; bin = vbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1; nbusy = 0;
      while (!done && lat < 40) begin
         if (busy) nbusy++;
         if (inj != 0 && lat == inj) begin
            start = 1'b1; a = ~va; b = va; bin = ~vbin;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk({name, " done"}, 32'(done), 32'd1);
      chk({name, " latency"}, lat, W + 1);
      chk({name, " busy_cycles"}, nbusy, W);
      chk({name, " busy_in_done"}, 32'(busy), 32'd0);
      chk({name, " diff"}, 32'(diff), 32'(ed));
      chk({name, " borrow"}, 32'(borrow), 32'(eb));
      if (p_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, " done_pulse_1cyc"}, 32'(done), 32'd0);
      chk({name, " diff_hold"}, 32'(diff), 32'(ed));
      if (p_done) chk({name, " start_in_done_ignored"}, 32'(busy), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      logic [W-1:0] ra, rb, ed;
      logic         rbin, eb;
      int           extra_done;

      vecs.push_back('{8'h35, 8'h12, 1'b0, 8'h23, 1'b0});
      vecs.push_back('{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1});
      vecs.push_back('{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0});
      vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1});
      vecs.push_back('{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0});
`ifdef SERIAL_SUB_BIN_EN
      vecs.push_back('{8'h10, 8'h05, 1'b1, 8'h0A, 1'b0});
      vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1});
      vecs.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
`endif

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset diff", 32'(diff), 32'd0);
      chk("reset borrow", 32'(borrow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table vectors, back-to-back (start in the IDLE cycle right after done)
      foreach (vecs[i]) begin
         model(vecs[i].va, vecs[i].vb, vecs[i].vbin, ed, eb);
         chk($sformatf("vec%0d model_d", i), 32'(ed), 32'(vecs[i].ed));
         chk($sformatf("vec%0d model_b", i), 32'(eb), 32'(vecs[i].eb));
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vbin, 0, 1'b0);
      end

      // Result stable across idle cycles with changing inputs
      a = 8'h5A; b = 8'hC3;
      repeat (3) @(negedge clk);
      model(vecs[vecs.size()-1].va, vecs[vecs.size()-1].vb, vecs[vecs.size()-1].vbin, ed, eb);
      chk("idle hold diff", 32'(diff), 32'(ed));
      chk("idle hold borrow", 32'(borrow), 32'(eb));
      chk("idle busy", 32'(busy), 32'd0);

      // Second start during SHIFT cycle 3 is ignored, single done pulse
      run_op("mid_start", 8'h35, 8'h12, 1'b0, 3, 1'b0);
      extra_done = 0;
      for (int c = 0; c < W + 2; c++) begin
         if (done || busy) extra_done++;
         @(negedge clk);
      end
      chk("mid_start no_second_op", extra_done, 0);

      // start during DONE is ignored
      run_op("start_in_done", 8'h12, 8'h35, 1'b0, 0, 1'b1);

      // Reset mid-operation at SHIFT cycle 4
      a = 8'h12; b = 8'h35; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst busy", 32'(busy), 32'd0);
      chk("mid_rst done", 32'(done), 32'd0);
      chk("mid_rst diff", 32'(diff), 32'd0);
      chk("mid_rst borrow", 32'(borrow), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_op("post_rst", 8'h35, 8'h12, 1'b0, 0, 1'b0);

      // Random operands
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SERIAL_SUB_BIN_EN
         rbin = 1'($urandom);
`else
         rbin = 1'b0;
`endif
         run_op($sformatf("rand%0d", n), ra, rb, rbin, 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
